// File: rtl/centroid_sequencer.sv
// Raster centroid sequencer: per-frame hit count and x/y coordinate sums feed one shared restoring divider (X, then Y).
// Latency: HOLD entered 2*SUM_WIDTH edges after the EOF edge (consumer first samples valid on EOF+2*SUM_WIDTH+1); empty frame enters HOLD on the EOF edge.
// Backpressure: result held in HOLD until position_ready; an EOF that arrives while not IDLE is discarded and frame_dropped pulses.
// Build option: define MEASURE_ROUND_EN to round the centroid to nearest (numerator = sum + count/2) instead of truncating.
module centroid_sequencer #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int COORD_WIDTH  = 11,
    parameter int COLOR_WIDTH  = 10,
    parameter int COUNT_WIDTH  = 19,
    parameter int SUM_WIDTH    = 27
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pixel_valid,
    input  logic [COLOR_WIDTH-1:0] delta_frame,
    output logic [COORD_WIDTH-1:0] x_position,
    output logic [COORD_WIDTH-1:0] y_position,
    output logic                   no_object,
    output logic                   position_valid,
    input  logic                   position_ready,
    output logic                   busy,
    output logic                   frame_dropped
);

    localparam int ITER_W = $clog2(SUM_WIDTH);
    localparam logic [COORD_WIDTH-1:0] X_LAST    = COORD_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST    = COORD_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [ITER_W-1:0]      ITER_LAST = ITER_W'(SUM_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] COORD_ONE = COORD_WIDTH'(1);
    localparam logic [ITER_W-1:0]      ITER_ONE  = ITER_W'(1);

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [COORD_WIDTH-1:0]  x_q, x_d, y_q, y_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [SUM_WIDTH-1:0]    xsum_q, xsum_d, ysum_q, ysum_d;
    logic [SUM_WIDTH-1:0]    num_q, num_d, ynum_q, ynum_d;
    logic [COUNT_WIDTH-1:0]  den_q, den_d, rem_q, rem_d;
    logic [ITER_W-1:0]       iter_q, iter_d;
    logic [COORD_WIDTH-1:0]  xres_q, xres_d, xpos_q, xpos_d, ypos_q, ypos_d;
    logic                    no_obj_q, no_obj_d, drop_q, drop_d;

    logic                    hit, eof, x_last, y_last;
    logic [COUNT_WIDTH-1:0]  count_fin;
    logic [SUM_WIDTH-1:0]    xsum_fin, ysum_fin, xnum_fin, ynum_fin;
    logic [COUNT_WIDTH:0]    trial;
    logic                    ge;
    logic [COUNT_WIDTH-1:0]  rem_nxt;
    logic [SUM_WIDTH-1:0]    quo_nxt;

    // Raster walk and per-frame accumulation; the EOF pixel's own hit is folded into the *_fin values.
    always_comb begin
        hit       = pixel_valid && (&delta_frame);
        x_last    = (x_q == X_LAST);
        y_last    = (y_q == Y_LAST);
        eof       = pixel_valid && x_last && y_last;
        count_fin = count_q + COUNT_WIDTH'(hit);
        xsum_fin  = xsum_q + (hit ? SUM_WIDTH'(x_q) : '0);
        ysum_fin  = ysum_q + (hit ? SUM_WIDTH'(y_q) : '0);
`ifdef MEASURE_ROUND_EN
        xnum_fin  = xsum_fin + SUM_WIDTH'(count_fin >> 1);
        ynum_fin  = ysum_fin + SUM_WIDTH'(count_fin >> 1);
`else
        xnum_fin  = xsum_fin;
        ynum_fin  = ysum_fin;
`endif
        x_d     = x_q;
        y_d     = y_q;
        count_d = count_q;
        xsum_d  = xsum_q;
        ysum_d  = ysum_q;
        if (pixel_valid) begin
            x_d     = x_last ? '0 : x_q + COORD_ONE;
            y_d     = x_last ? (y_last ? '0 : y_q + COORD_ONE) : y_q;
            count_d = count_fin;
            xsum_d  = xsum_fin;
            ysum_d  = ysum_fin;
        end
        // Accumulators restart at every EOF, whether or not the frame is accepted.
        if (eof) begin
            count_d = '0;
            xsum_d  = '0;
            ysum_d  = '0;
        end
    end

    // Division sequencing: next state, divider step, and result capture on entry to HOLD.
    always_comb begin
        trial   = {rem_q, num_q[SUM_WIDTH-1]};
        ge      = (trial >= {1'b0, den_q});
        rem_nxt = COUNT_WIDTH'(ge ? (trial - {1'b0, den_q}) : trial);
        quo_nxt = {num_q[SUM_WIDTH-2:0], ge};

        state_d  = state_q;
        num_d    = num_q;
        ynum_d   = ynum_q;
        den_d    = den_q;
        rem_d    = rem_q;
        iter_d   = iter_q;
        xres_d   = xres_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        no_obj_d = no_obj_q;
        drop_d   = eof && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (eof) begin
                    if (count_fin != '0) begin
                        num_d   = xnum_fin;
                        ynum_d  = ynum_fin;
                        den_d   = count_fin;
                        rem_d   = '0;
                        iter_d  = '0;
                        state_d = DIV_X;
                    end else begin
                        xpos_d   = '0;
                        ypos_d   = '0;
                        no_obj_d = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            DIV_X: begin
                num_d  = quo_nxt;
                rem_d  = rem_nxt;
                iter_d = iter_q + ITER_ONE;
                // Last X bit: park the X quotient and restart the same divider on Y.
                if (iter_q == ITER_LAST) begin
                    xres_d  = COORD_WIDTH'(quo_nxt);
                    num_d   = ynum_q;
                    rem_d   = '0;
                    iter_d  = '0;
                    state_d = DIV_Y;
                end
            end
            DIV_Y: begin
                num_d  = quo_nxt;
                rem_d  = rem_nxt;
                iter_d = iter_q + ITER_ONE;
                if (iter_q == ITER_LAST) begin
                    xpos_d   = xres_q;
                    ypos_d   = COORD_WIDTH'(quo_nxt);
                    no_obj_d = 1'b0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (position_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Scan, operand, divider and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            count_q  <= '0;
            xsum_q   <= '0;
            ysum_q   <= '0;
            num_q    <= '0;
            ynum_q   <= '0;
            den_q    <= '0;
            rem_q    <= '0;
            iter_q   <= '0;
            xres_q   <= '0;
            xpos_q   <= '0;
            ypos_q   <= '0;
            no_obj_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            count_q  <= count_d;
            xsum_q   <= xsum_d;
            ysum_q   <= ysum_d;
            num_q    <= num_d;
            ynum_q   <= ynum_d;
            den_q    <= den_d;
            rem_q    <= rem_d;
            iter_q   <= iter_d;
            xres_q   <= xres_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            no_obj_q <= no_obj_d;
            drop_q   <= drop_d;
        end
    end

    assign x_position     = xpos_q;
    assign y_position     = ypos_q;
    assign no_object      = no_obj_q;
    assign position_valid = (state_q == HOLD);
    assign busy           = (state_q != IDLE);
    assign frame_dropped  = drop_q;

endmodule

// File: doc/centroid_sequencer.md
# centroid_sequencer

Controls the object-centroid datapath. It walks raster coordinates over a stream of thresholded delta-frame pixels and accumulates the coordinate sums and hit count for each frame. At end of frame it schedules one shared sequential divider to produce the centroid X and then Y, and hands the result downstream with a valid/ready handshake. It sits between the frame-difference stage and the tracking/display consumer, and double-buffers so that scanning of frame N+1 overlaps division of frame N.

## Interface
- FRAME_WIDTH, 640, active pixels per line
- FRAME_HEIGHT, 480, active lines per frame
- COORD_WIDTH, 11, x/y counter and centroid output width
- COLOR_WIDTH, 10, delta_frame width
- COUNT_WIDTH, 19, hit-count width
- SUM_WIDTH, 27, coordinate-sum width and divider iteration count
- clk  in  1  clock; one clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pixel_valid  in  1  delta_frame carries one raster-ordered pixel this cycle
- delta_frame  in  COLOR_WIDTH  pixel is a hit when all bits are 1
- x_position  out  COORD_WIDTH  centroid X
- y_position  out  COORD_WIDTH  centroid Y
- no_object  out  1  qualifies the result: frame had zero hits
- position_valid  out  1  result available
- position_ready  in  1  consumer accepts the result
- busy  out  1  divider state machine not in IDLE
- frame_dropped  out  1  one-cycle pulse when a finished frame is discarded

## Operation
**Scan (always active)**
- On each pixel_valid cycle: if &delta_frame, then count+=1, xsum+=x, ysum+=y. Then x increments.
- At x==FRAME_WIDTH-1, x wraps to 0 and y increments.
- At (FRAME_WIDTH-1, FRAME_HEIGHT-1), x and y both wrap to 0. This is end of frame (EOF). The last pixel's hit is included in the frame's sums.
- Counters and sums hold when pixel_valid is low.

**EOF hand-off**
- At EOF, if the state is IDLE, the final count/xsum/ysum are copied into the divider operand registers and the accumulators clear to zero on the same edge.
- At EOF, if the state is not IDLE, the frame's sums are discarded, the accumulators clear, and frame_dropped pulses.

**Division state machine: IDLE → DIV_X → DIV_Y → HOLD → IDLE**
- IDLE → DIV_X on EOF when count≠0.
- IDLE → HOLD on EOF when count==0. In this case x_position=0, y_position=0, no_object=1, and no division is performed.
- DIV_X: restoring divide of xsum by count, SUM_WIDTH cycles, one quotient bit per cycle, MSB first.
- DIV_Y: the same divide for ysum.
- HOLD: position_valid=1.
- HOLD → IDLE on the first edge where position_ready=1.
- Quotients are truncated to COORD_WIDTH. This is lossless, because the centroid never exceeds the maximum coordinate.
- Outputs update only on entry to HOLD, and stay stable for the whole HOLD period.

**Reset**
- Reset dominates everything, including in mid-division or mid-frame.
- All counters, sums, operands, and the state are cleared; the state goes to IDLE.
- Outputs after reset: x_position=0, y_position=0, no_object=0, position_valid=0, busy=0, frame_dropped=0.

## Timing
- EOF pixel sampled at edge E0. With a non-empty frame, position_valid rises at edge E0+2·SUM_WIDTH+1, which is 55 cycles with the default parameters.
- With an empty frame, position_valid rises at edge E0+1.
- busy is high from edge E0 until the edge on which the handshake completes.
- A handshake occurs when position_valid & position_ready are both high at an edge. The state returns to IDLE at that edge, and position_valid is low in the following cycle.
- An EOF arriving on the same edge as the handshake is dropped, because the state is not IDLE at that edge. Minimum frame spacing is therefore determined by the consumer.
- frame_dropped is high for exactly one cycle, at the cycle after the dropped EOF edge.

## Configuration
- MEASURE_ROUND_EN defined: the numerator for each division is sum + (count>>1), so the centroid rounds to the nearest integer. This adds no latency.
- MEASURE_ROUND_EN undefined: the numerator is the raw sum, so the centroid truncates toward zero.

## Test plan
- Single hit at (100,50), pixel_valid always 1, position_ready=1 → x=100, y=50, no_object=0; position_valid high for 1 cycle, 55 cycles after EOF.
- Hits at (10,10), (11,10), (10,11), (11,11) → x=10, y=10 without MEASURE_ROUND_EN; x=11, y=11 with it.
- Frame with no hits → x=0, y=0, no_object=1; position_valid at EOF+1; busy for exactly 1 cycle.
- Two consecutive frames with position_ready held 0 → first result stays stable in HOLD; frame_dropped pulses once at the second EOF; after ready, the third frame's result is correct.
- pixel_valid toggling 1/0 every cycle, single hit at (639,479) → centroid (639,479); counters advance only on valid cycles.
- reset asserted for 1 cycle during DIV_Y → next cycle all outputs zero and busy=0; the following full frame with a hit at (5,7) yields (5,7).
